// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, router state and index helpers for the 32-point FFT
//
// Purpose: common definitions for the FFT input loader and the output-reorder stage.
//   N_POINTS / LOG2N       : transform size and index width
//   BANKS / BANK_DEPTH     : four sample banks of eight entries each
//   router_state_t         : loader FSM states (LOAD accepts samples, FULL waits for ack)
//   bitrev5()              : 5-bit index bit reversal
package fft_pkg;

  localparam int N_POINTS   = 32;
  localparam int LOG2N      = 5;
  localparam int BANKS      = 4;
  localparam int BANK_DEPTH = 8;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } router_state_t;

  function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int k = 0; k < LOG2N; k++) begin
      r[k] = idx[LOG2N-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse.sv
// rtl/bit_reverse.sv - combinational index bit reversal
//
// Purpose: mirrors the bit order of an index; shared by the input loader and the
// output-reorder stage.
// Ports:
//   in_idx  : natural-order index
//   out_idx : bit-reversed index (in_idx[0] lands in out_idx[WIDTH-1])
module bit_reverse
  import fft_pkg::*;
#(
  parameter int WIDTH = LOG2N
) (
  input  logic [WIDTH-1:0] in_idx,
  output logic [WIDTH-1:0] out_idx
);

  always_comb begin
    out_idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      out_idx[k] = in_idx[WIDTH-1-k];
    end
  end

endmodule

// File: rtl/fft_sample_router.sv
// rtl/fft_sample_router.sv - natural-order sample loader into bit-reversed FFT banks
//
// Purpose: accepts a serial natural-order sample stream and writes each sample into
// one of four 8-entry banks at its bit-reversed position, so the FFT core sees its
// input in decimation-in-time order. After 32 samples the frame is held until the
// core acknowledges it.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_data     : natural-order sample
//   in_valid    : in_data is valid
//   in_ready    : router can accept a sample (decoded from state only)
//   frame_ack   : one-cycle pulse from the FFT core, banks consumed
//   demux_data  : registered sample to the 1:4 demux
//   demux_sel   : registered bank select (bit-reversed index [4:3])
//   bank_addr   : registered in-bank address (bit-reversed index [2:0])
//   bank_we     : registered write strobe
//   sample_cnt  : samples accepted in the current frame, modulo 32
//   frame_ready : a complete frame is resident in the banks
module fft_sample_router
  import fft_pkg::*;
#(
  parameter int number_bits = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [number_bits-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   frame_ack,
  output logic [number_bits-1:0] demux_data,
  output logic [1:0]             demux_sel,
  output logic [2:0]             bank_addr,
  output logic                   bank_we,
  output logic [4:0]             sample_cnt,
  output logic                   frame_ready
);

  router_state_t    state;
  logic             accept;
  logic             last_accept;
  logic             last_wr;
  logic             ack_taken;
  logic [LOG2N-1:0] rev_idx;

  bit_reverse #(.WIDTH(LOG2N)) u_bit_reverse (
    .in_idx  (sample_cnt),
    .out_idx (rev_idx)
  );

  // State is a flop, so in_ready has no combinational path from any input.
  assign in_ready    = (state == LOAD);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (sample_cnt == 5'd31);

  // An ack only counts once frame_ready is already up; this drops acks that land
  // on the final accept or in the one-cycle gap before frame_ready rises.
  assign ack_taken   = frame_ack && frame_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      sample_cnt  <= '0;
      demux_data  <= '0;
      demux_sel   <= '0;
      bank_addr   <= '0;
      bank_we     <= 1'b0;
      last_wr     <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      bank_we <= accept;
      last_wr <= last_accept;

      if (accept) begin
        demux_data <= in_data;
        demux_sel  <= rev_idx[4:3];
        bank_addr  <= rev_idx[2:0];
        sample_cnt <= sample_cnt + 5'd1;
      end

      case (state)
        LOAD: if (last_accept) state <= FULL;
        FULL: if (ack_taken)   state <= LOAD;
        default:               state <= LOAD;
      endcase

      // last_wr is high in the cycle carrying the final bank_we, so frame_ready
      // rises on the edge that ends that cycle.
      if (ack_taken) begin
        frame_ready <= 1'b0;
      end else if (last_wr) begin
        frame_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_sample_router.sv
// tb/tb_fft_sample_router.sv - self-checking bench for fft_sample_router
module tb_fft_sample_router;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         frame_ack = 1'b0;
  logic         in_ready;
  logic [W-1:0] demux_data;
  logic [1:0]   demux_sel;
  logic [2:0]   bank_addr;
  logic         bank_we;
  logic [4:0]   sample_cnt;
  logic         frame_ready;

  fft_sample_router #(.number_bits(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_ack   (frame_ack),
    .demux_data  (demux_data),
    .demux_sel   (demux_sel),
    .bank_addr   (bank_addr),
    .bank_we     (bank_we),
    .sample_cnt  (sample_cnt),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev5(input int i);
    int r;
    r = 0;
    for (int k = 0; k < 5; k++) r = r + (((i >> k) & 1) << (4 - k));
    return r;
  endfunction

  // Behavioural model: a count of samples stored in the current frame (32 = full
  // frame resident), the age of a full frame in cycles, and the last write.
  int           m_stored = 0;
  int           m_age = 0;
  logic         m_we = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [1:0]   m_sel = '0;
  logic [2:0]   m_addr = '0;
  bit           m_acc;
  bit           m_ack_ok;
  int           m_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stored = 0;
      m_age    = 0;
      m_we     = 1'b0;
      m_data   = '0;
      m_sel    = '0;
      m_addr   = '0;
    end else begin
      m_acc    = in_valid && (m_stored < 32);
      m_ack_ok = frame_ack && (m_stored == 32) && (m_age >= 1);
      m_we     = m_acc;
      if (m_acc) begin
        m_r      = rev5(m_stored);
        m_sel    = 2'(m_r / 8);
        m_addr   = 3'(m_r % 8);
        m_data   = in_data;
        m_stored = m_stored + 1;
        m_age    = 0;
      end else if (m_ack_ok) begin
        m_stored = 0;
        m_age    = 0;
      end else if (m_stored == 32 && m_age < 2) begin
        m_age = m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready",    32'(in_ready),    32'(m_stored < 32));
    check("sample_cnt",  32'(sample_cnt),  32'(m_stored % 32));
    check("frame_ready", 32'(frame_ready), 32'((m_stored == 32) && (m_age >= 1)));
    check("bank_we",     32'(bank_we),     32'(m_we));
    check("demux_data",  32'(demux_data),  32'(m_data));
    check("demux_sel",   32'(demux_sel),   32'(m_sel));
    check("bank_addr",   32'(bank_addr),   32'(m_addr));
  end

  logic [7:0] bank_mask [4];

  always @(negedge clk) begin
    if (bank_we === 1'b1) bank_mask[demux_sel][bank_addr] = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input int sel, input int addr, input int data);
    check({tag, "_we"},   32'(bank_we),    32'd1);
    check({tag, "_sel"},  32'(demux_sel),  32'(sel));
    check({tag, "_addr"}, 32'(bank_addr),  32'(addr));
    check({tag, "_data"}, 32'(demux_data), 32'(data));
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_in_ready"},    32'(in_ready),    32'd1);
    check({tag, "_bank_we"},     32'(bank_we),     32'd0);
    check({tag, "_demux_data"},  32'(demux_data),  32'd0);
    check({tag, "_demux_sel"},   32'(demux_sel),   32'd0);
    check({tag, "_bank_addr"},   32'(bank_addr),   32'd0);
    check({tag, "_sample_cnt"},  32'(sample_cnt),  32'd0);
    check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
  endtask

  int accepted;
  int cycles;

  initial begin
    for (int b = 0; b < 4; b++) bank_mask[b] = '0;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Frame 1: 32 gapless samples, value = index + 0x100.
    for (int i = 0; i < 32; i++) begin
      in_data  = 16'(16'h100 + i);
      in_valid = 1'b1;
      step();
      if (i == 0)  expect_write("idx0",  0, 0, 16'h100);
      if (i == 1)  expect_write("idx1",  2, 0, 16'h101);
      if (i == 6)  expect_write("idx6",  1, 4, 16'h106);
      if (i == 31) begin
        expect_write("idx31", 3, 7, 16'h11F);
        check("idx31_frame_ready_low", 32'(frame_ready), 32'd0);
        check("idx31_in_ready_low",    32'(in_ready),    32'd0);
      end
    end

    // in_valid stays high through FULL.
    in_data = 16'hBEEF;
    step();
    check("fr_rise_frame_ready", 32'(frame_ready), 32'd1);
    check("fr_rise_bank_we",     32'(bank_we),     32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      check("full_hold_bank_we",    32'(bank_we),    32'd0);
      check("full_hold_in_ready",   32'(in_ready),   32'd0);
      check("full_hold_sample_cnt", 32'(sample_cnt), 32'd0);
    end

    // Ack in FULL; in_valid still high, so the first post-ack edge accepts index 0.
    for (int b = 0; b < 4; b++) bank_mask[b] = '0;
    in_data   = 16'h2AA;
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("ack_frame_ready", 32'(frame_ready), 32'd0);
    check("ack_in_ready",    32'(in_ready),    32'd1);
    check("ack_bank_we",     32'(bank_we),     32'd0);
    step();
    expect_write("post_ack_idx0", 0, 0, 16'h2AA);
    check("post_ack_cnt", 32'(sample_cnt), 32'd1);

    // Remaining 31 accepts with random in_valid gaps.
    accepted = 1;
    cycles   = 0;
    while (accepted < 32 && cycles < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'(16'h200 + accepted);
      if (in_valid && in_ready) accepted++;
      step();
      cycles++;
    end
    in_valid = 1'b0;
    check("gap_accepts", 32'(accepted), 32'd32);
    step();
    for (int b = 0; b < 4; b++) check("gap_bank_mask", 32'(bank_mask[b]), 32'hFF);
    check("gap_frame_ready", 32'(frame_ready), 32'd1);
    check("gap_in_ready",    32'(in_ready),    32'd0);

    // Reset after 13 accepts.
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("ack2_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 13; i++) begin
      in_data  = 16'(16'h300 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_cnt", 32'(sample_cnt), 32'd13);
    #3 rst = 1'b1;
    #1;
    expect_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    expect_reset_outputs("post_rst");
    in_data  = 16'h3AB;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    expect_write("post_rst_idx0", 0, 0, 16'h3AB);
    check("post_rst_cnt", 32'(sample_cnt), 32'd1);

    // Clean slate, then ack in LOAD is ignored.
    rst = 1'b1;
    step();
    rst = 1'b0;
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("load_ack_in_ready",    32'(in_ready),    32'd1);
    check("load_ack_cnt",         32'(sample_cnt),  32'd0);
    check("load_ack_frame_ready", 32'(frame_ready), 32'd0);

    // Ack coincident with the 32nd accept, and in the gap cycle: both ignored.
    for (int i = 0; i < 32; i++) begin
      in_data   = 16'(16'h400 + i);
      in_valid  = 1'b1;
      frame_ack = (i == 31);
      step();
    end
    in_valid  = 1'b0;
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("coinc_frame_ready", 32'(frame_ready), 32'd1);
    check("coinc_in_ready",    32'(in_ready),    32'd0);
    repeat (3) step();
    check("coinc_hold_frame_ready", 32'(frame_ready), 32'd1);
    check("coinc_hold_in_ready",    32'(in_ready),    32'd0);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("fresh_ack_in_ready",    32'(in_ready),    32'd1);
    check("fresh_ack_frame_ready", 32'(frame_ready), 32'd0);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check("load_ack2_in_ready",    32'(in_ready),    32'd1);
    check("load_ack2_frame_ready", 32'(frame_ready), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_sample_router.md
# fft_sample_router

Input-side loader for the 32-point radix-2 FFT. Accepts a serial stream of natural-order samples over a valid/ready handshake and bit-reverses each sample index. It drives the downstream 1:4 demux with registered data, a 2-bit bank select and a 3-bit in-bank address, so the four 8-entry sample banks are filled in decimation-in-time order. It raises `frame_ready` when a full 32-sample frame is stored, then holds off input until the FFT core acknowledges the frame.

## Interface
- `number_bits`, default 16: sample width; must match the demux width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input `number_bits`: natural-order sample.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the router can accept a sample.
- `frame_ack` input 1: one-cycle pulse from the FFT core; the banks have been consumed.
- `demux_data` output `number_bits`: registered sample, goes to the demux `in`.
- `demux_sel` output 2: registered bank select, goes to the demux `sel`.
- `bank_addr` output 3: registered write address within the selected bank.
- `bank_we` output 1: registered write strobe for the selected bank.
- `sample_cnt` output 5: number of samples accepted in the current frame, modulo 32.
- `frame_ready` output 1: a complete frame is resident in the banks.

## Operation
- FSM states:
  - LOAD: `in_ready`=1.
  - FULL: `in_ready`=0.
- A sample is accepted when `in_valid` and `in_ready` are both high on a rising edge.
- On accept with index i = `sample_cnt`:
  - Compute r = bitrev5(i).
  - Register `demux_sel` = r[4:3], `bank_addr` = r[2:0], `demux_data` = `in_data`, `bank_we` = 1.
  - Increment `sample_cnt`; it wraps 31→0.
- Cycles with no accept: `bank_we` = 0. `demux_data`, `demux_sel` and `bank_addr` hold their last values.
- Frame completion:
  - LOAD→FULL on accept of index 31; `sample_cnt` wraps to 0.
  - `frame_ready` rises one cycle after the final `bank_we`.
- FULL→LOAD on `frame_ack`=1. `frame_ready` clears on the same edge; `in_ready` returns next cycle.
- Boundary cases:
  - `frame_ack` in LOAD is ignored.
  - `frame_ack` coincident with the index-31 accept is ignored; the core must ack again in FULL.
  - `frame_ack` in the cycle between the last write and `frame_ready` rising is ignored.
  - `in_valid` held high in FULL causes no accept and no `bank_we`.
  - `in_valid` gaps mid-frame are legal; the index does not advance.
- Reset, including mid-frame:
  - State = LOAD; all outputs 0 except `in_ready` = 1.
  - A partial frame is discarded; the next accepted sample is index 0.

## Timing
- Accept→`bank_we` latency: 1 cycle. Data, select and address are aligned with `bank_we`.
- Throughput: 1 sample per cycle in LOAD, so a back-to-back frame is 32 cycles.
- If index 0 is accepted at edge t0 and the stream is gapless:
  - Last accept at t0+31; last `bank_we` in the cycle after t0+31.
  - `frame_ready` is high from the cycle after t0+32.
- `frame_ack` sampled at edge ta gives `in_ready` = 1 in the cycle after ta.
- `in_ready` is a registered function of state only. It has no combinational path from `in_valid` or `frame_ack`.

## Structure
- Shared package `fft_pkg` holds:
  - `N_POINTS` = 32, `LOG2N` = 5.
  - `BANKS` = 4, `BANK_DEPTH` = 8.
  - The router state enum (LOAD, FULL).
  - A `bitrev5` function.
- Sub-module `bit_reverse`: combinational, parameterised on `LOG2N`. It is reused by the output-reorder stage, so it stays a separate module.

## Test plan
- Reset, then 32 gapless samples with value = index+0x100:
  - Index 0 → sel 00, addr 0.
  - Index 1 → sel 10, addr 0.
  - Index 6 → sel 01, addr 4.
  - Index 31 → sel 11, addr 7.
  - `frame_ready` high 1 cycle after the last `bank_we`.
- Hold `in_valid` high in FULL for 10 cycles: no `bank_we`, `in_ready` = 0, `sample_cnt` = 0.
- `frame_ack` pulse in FULL:
  - `frame_ready` clears; `in_ready` = 1 the next cycle.
  - The next sample writes sel 00, addr 0.
- Random `in_valid` gaps over 32 accepts: the addresses written to each bank are exactly {0..7}, and every index maps per `bitrev5`.
- Assert `rst` after 13 accepts: all outputs 0, `in_ready` = 1; the next accept is index 0 (sel 00, addr 0).
- `frame_ack` coincident with the 32nd accept, and again in LOAD: both ignored; state stays FULL until a fresh ack.
